mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_if.sv | 27 ++
 rtl/mem_loader.sv | 149 ++++++++++++++
 tb/tb_mem_loader.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_loader_if.sv
// mem_loader_if: byte-stream receive channel plus external data-memory write bus.
//   rx_valid      upstream has a byte on rx_data
//   rx_data[7:0]  byte payload
//   rx_ready      loader accepts the byte this cycle
//   Ext_MemWrite  one-cycle write strobe toward the CPU data memory
//   Ext_WriteData write word
//   Ext_DataAdr   write byte address
// modport slave  : the loader side
// modport master : the environment side (byte source / memory sink)
interface mem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        Ext_MemWrite;
    logic [31:0] Ext_WriteData;
    logic [31:0] Ext_DataAdr;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, Ext_MemWrite, Ext_WriteData, Ext_DataAdr
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, Ext_MemWrite, Ext_WriteData, Ext_DataAdr
    );
endinterface

// File: rtl/mem_loader.sv
// mem_loader: receives a little-endian word count followed by that many
// little-endian 32-bit words over a byte stream and writes them to external
// data memory at BASE_ADDR, BASE_ADDR+4, ... while holding the CPU in reset.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low
//   start      one-cycle pulse that opens a load session (ignored while busy)
//   bus        mem_loader_if.slave: rx byte stream in, memory write bus out
//   cpu_reset  active-high CPU reset, released only after a completed load
//   busy       session in progress
//   done       load completed
//   error      word count exceeded MAX_WORDS
//
// state | meaning
// IDLE  | after reset, waiting for start
// CNT   | collecting the 4 word-count bytes
// DATA  | collecting the 4 bytes of the current word
// WRITE | single-cycle memory write of the assembled word
// DONE  | all words written, CPU released
// ERR   | word count out of range, CPU held
module mem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    mem_loader_if.slave  bus,
    output logic         cpu_reset,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        CNT,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [23:0] byte_buf;
    logic [31:0] word_count;
    logic [31:0] index;
    logic [31:0] word_next;
    logic        accept;

    // The 4th byte completes the word directly from the input, so no extra
    // cycle is spent between the last byte and the decision/write.
    assign word_next = {bus.rx_data, byte_buf};
    assign accept    = bus.rx_valid & bus.rx_ready;

    // Status outputs are a pure function of the state being entered; they are
    // loaded together with the state so they stay glitch-free registers.
    // Bit order: {rx_ready, cpu_reset, busy, done, error}
    function automatic logic [4:0] flags_for(input state_t s);
        case (s)
            CNT, DATA: return 5'b11100;
            WRITE:     return 5'b01100;
            DONE:      return 5'b00010;
            ERR:       return 5'b01001;
            default:   return 5'b01000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            byte_cnt          <= 2'd0;
            byte_buf          <= 24'd0;
            word_count        <= 32'd0;
            index             <= 32'd0;
            bus.Ext_MemWrite  <= 1'b0;
            bus.Ext_WriteData <= 32'd0;
            bus.Ext_DataAdr   <= 32'd0;
            {bus.rx_ready, cpu_reset, busy, done, error} <= flags_for(IDLE);
        end else begin
            bus.Ext_MemWrite <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state      <= CNT;
                        byte_cnt   <= 2'd0;
                        word_count <= 32'd0;
                        index      <= 32'd0;
                        {bus.rx_ready, cpu_reset, busy, done, error} <= flags_for(CNT);
                    end
                end

                CNT: begin
                    if (accept) begin
                        byte_buf <= {bus.rx_data, byte_buf[23:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            word_count <= word_next;
                            if (word_next == 32'd0) begin
                                state <= DONE;
                                {bus.rx_ready, cpu_reset, busy, done, error} <= flags_for(DONE);
                            end else if (word_next > MAX_N) begin
                                state <= ERR;
                                {bus.rx_ready, cpu_reset, busy, done, error} <= flags_for(ERR);
                            end else begin
                                state <= DATA;
                                {bus.rx_ready, cpu_reset, busy, done, error} <= flags_for(DATA);
                            end
                        end
                    end
                end

                DATA: begin
                    if (accept) begin
                        byte_buf <= {bus.rx_data, byte_buf[23:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            bus.Ext_WriteData <= word_next;
                            bus.Ext_DataAdr   <= BASE_ADDR + (index << 2);
                            bus.Ext_MemWrite  <= 1'b1;
                            state             <= WRITE;
                            {bus.rx_ready, cpu_reset, busy, done, error} <= flags_for(WRITE);
                        end
                    end
                end

                WRITE: begin
                    index <= index + 32'd1;
                    if (index + 32'd1 == word_count) begin
                        state <= DONE;
                        {bus.rx_ready, cpu_reset, busy, done, error} <= flags_for(DONE);
                    end else begin
                        state <= DATA;
                        {bus.rx_ready, cpu_reset, busy, done, error} <= flags_for(DATA);
                    end
                end

                default: begin
                    state <= IDLE;
                    {bus.rx_ready, cpu_reset, busy, done, error} <= flags_for(IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: two loaders (base 0x0 and base 0x100) driven by the same
// byte stream, compared every cycle against a session-level model, plus
// literal checks on the write log for the directed scenarios.
module tb_mem_loader;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic rx_valid = 1'b0;
    logic [7:0] rx_data = 8'd0;

    always #5 clk = ~clk;

    mem_loader_if if0 ();
    mem_loader_if if1 ();

    assign if0.rx_valid = rx_valid;
    assign if0.rx_data  = rx_data;
    assign if1.rx_valid = rx_valid;
    assign if1.rx_data  = rx_data;

    logic cpu_reset0, busy0, done0, error0;
    logic cpu_reset1, busy1, done1, error1;

    mem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(64)) dut0 (
        .clk(clk), .reset(reset), .start(start), .bus(if0.slave),
        .cpu_reset(cpu_reset0), .busy(busy0), .done(done0), .error(error0)
    );

    mem_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(64)) dut1 (
        .clk(clk), .reset(reset), .start(start), .bus(if1.slave),
        .cpu_reset(cpu_reset1), .busy(busy1), .done(done1), .error(error1)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- session-level reference model ----------------
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;
    localparam int M_ERR  = 3;

    int          mode = M_IDLE;
    int          nb = 0;
    logic        wp = 1'b0;
    logic        acc;
    logic [31:0] widx = 32'd0;
    logic [31:0] nwords = 32'd0;
    logic [31:0] word;
    logic [31:0] e_data = 32'd0;
    logic [31:0] e_adr0 = 32'd0;
    logic [31:0] e_adr1 = 32'd0;
    logic [7:0]  mq[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode = M_IDLE; wp = 1'b0; nb = 0; widx = 32'd0; nwords = 32'd0;
            mq.delete();
            e_data = 32'd0; e_adr0 = 32'd0; e_adr1 = 32'd0;
        end else begin
            acc = rx_valid && (mode == M_LOAD) && !wp;
            if (mode == M_LOAD) begin
                if (wp) begin
                    wp = 1'b0;
                    widx = widx + 32'd1;
                    if (widx == nwords) mode = M_DONE;
                end else if (acc) begin
                    mq.push_back(rx_data);
                    nb++;
                    if (mq.size() == 4) begin
                        word = 32'(mq[0]) + (32'(mq[1]) << 8) + (32'(mq[2]) << 16) + (32'(mq[3]) << 24);
                        mq.delete();
                        if (nb == 4) begin
                            nwords = word;
                            if (word == 32'd0) mode = M_DONE;
                            else if (word > 32'd64) mode = M_ERR;
                        end else begin
                            wp = 1'b1;
                            e_data = word;
                            e_adr0 = 32'h0000_0000 + 32'd4 * widx;
                            e_adr1 = 32'h0000_0100 + 32'd4 * widx;
                        end
                    end
                end
            end else if (start) begin
                mode = M_LOAD; nb = 0; widx = 32'd0; mq.delete();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [69:0] exp0, exp1, got0, got1;
    int cyc = 0;

    always @(negedge clk) begin
        cyc++;
        exp0 = {(mode == M_LOAD) && !wp, wp, e_data, e_adr0,
                mode != M_DONE, mode == M_LOAD, mode == M_DONE, mode == M_ERR};
        exp1 = {(mode == M_LOAD) && !wp, wp, e_data, e_adr1,
                mode != M_DONE, mode == M_LOAD, mode == M_DONE, mode == M_ERR};
        got0 = {if0.rx_ready, if0.Ext_MemWrite, if0.Ext_WriteData, if0.Ext_DataAdr,
                cpu_reset0, busy0, done0, error0};
        got1 = {if1.rx_ready, if1.Ext_MemWrite, if1.Ext_WriteData, if1.Ext_DataAdr,
                cpu_reset1, busy1, done1, error1};
        checks++;
        if (got0 !== exp0) begin
            errors++;
            $display("FAIL cycle_dut0 cyc=%0d got=%h expected=%h", cyc, got0, exp0);
        end
        checks++;
        if (got1 !== exp1) begin
            errors++;
            $display("FAIL cycle_dut1 cyc=%0d got=%h expected=%h", cyc, got1, exp1);
        end
    end

    // ---------------- write logs ----------------
    logic [31:0] log0_d[$], log0_a[$], log1_d[$], log1_a[$];

    always @(negedge clk) begin
        if (if0.Ext_MemWrite === 1'b1) begin
            log0_d.push_back(if0.Ext_WriteData);
            log0_a.push_back(if0.Ext_DataAdr);
        end
        if (if1.Ext_MemWrite === 1'b1) begin
            log1_d.push_back(if1.Ext_WriteData);
            log1_a.push_back(if1.Ext_DataAdr);
        end
    end

    // ---------------- helpers ----------------
    logic [7:0] tx_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic clear_logs();
        log0_d.delete(); log0_a.delete(); log1_d.delete(); log1_a.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        tx_q.push_back(w[7:0]);
        tx_q.push_back(w[15:8]);
        tx_q.push_back(w[23:16]);
        tx_q.push_back(w[31:24]);
    endtask

    // pct < 0 : rx_valid toggles every cycle; otherwise valid with pct% chance
    task automatic send(input int pct);
        int   tries;
        logic rdy;
        logic ok;
        logic tog;
        tog = 1'b0;
        while (tx_q.size() > 0) begin
            ok = 1'b0;
            tries = 0;
            while (!ok) begin
                @(negedge clk);
                rdy = if0.rx_ready;
                if (pct < 0) begin
                    tog = ~tog;
                    rx_valid = tog;
                end else begin
                    rx_valid = ($urandom_range(99) < pct);
                end
                rx_data = rx_valid ? tx_q[0] : 8'($urandom);
                @(posedge clk);
                ok = rx_valid && rdy;
                tries++;
                if (!ok && tries > 400) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: got no accept after %0d cycles expected accept", tries);
                    tx_q.delete();
                    @(negedge clk);
                    rx_valid = 1'b0;
                    return;
                end
            end
            void'(tx_q.pop_front());
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rx_ready"},  32'(if0.rx_ready), 32'd0);
        chk({tag, "_memwrite"},  32'(if0.Ext_MemWrite), 32'd0);
        chk({tag, "_wdata"},     if0.Ext_WriteData, 32'd0);
        chk({tag, "_adr"},       if1.Ext_DataAdr, 32'd0);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset0), 32'd1);
        chk({tag, "_flags"},     32'({busy0, done0, error0, busy1, done1, error1}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    int n_rand;
    int exp_writes;

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // two-word program at base 0
        clear_logs();
        pulse_start();
        push_word(32'd2);
        push_word(32'h00A0_0513);
        push_word(32'h0010_0593);
        send(100);
        repeat (4) @(negedge clk);
        chk("prog_nwrites", 32'(log0_d.size()), 32'd2);
        chk("prog_d0", log0_d[0], 32'h00A0_0513);
        chk("prog_a0", log0_a[0], 32'h0000_0000);
        chk("prog_d1", log0_d[1], 32'h0010_0593);
        chk("prog_a1", log0_a[1], 32'h0000_0004);
        chk("prog_a1_base100", log1_a[1], 32'h0000_0104);
        chk("prog_done", 32'(done0), 32'd1);
        chk("prog_cpu_reset", 32'(cpu_reset0), 32'd0);

        // zero count -> straight to DONE
        clear_logs();
        pulse_start();
        chk("restart_cpu_reset", 32'(cpu_reset0), 32'd1);
        push_word(32'd0);
        send(100);
        repeat (3) @(negedge clk);
        chk("zero_nwrites", 32'(log0_d.size()), 32'd0);
        chk("zero_done", 32'(done0), 32'd1);
        chk("zero_cpu_reset", 32'(cpu_reset0), 32'd0);

        // count 65 -> ERR, then restart
        clear_logs();
        pulse_start();
        push_word(32'd65);
        send(100);
        repeat (3) @(negedge clk);
        chk("err_error", 32'(error0), 32'd1);
        chk("err_cpu_reset", 32'(cpu_reset0), 32'd1);
        chk("err_rx_ready", 32'(if0.rx_ready), 32'd0);
        chk("err_nwrites", 32'(log0_d.size()), 32'd0);
        pulse_start();
        chk("err_restart_error", 32'(error0), 32'd0);
        chk("err_restart_busy", 32'(busy0), 32'd1);

        // already in CNT: one word, valid toggling, check base 0x100 instance
        push_word(32'd1);
        push_word(32'hDEAD_BEEF);
        send(-1);
        repeat (4) @(negedge clk);
        chk("toggle_nwrites", 32'(log1_d.size()), 32'd1);
        chk("toggle_a", log1_a[0], 32'h0000_0100);
        chk("toggle_d", log1_d[0], 32'hDEAD_BEEF);
        chk("toggle_done", 32'(done1), 32'd1);

        // reset in the middle of word 0
        clear_logs();
        pulse_start();
        push_word(32'd1);
        tx_q.push_back(8'hAA);
        tx_q.push_back(8'hBB);
        send(100);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_reset_values("midreset");
        repeat (3) @(negedge clk);
        chk("midreset_nwrites", 32'(log0_d.size() + log1_d.size()), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // start during DATA is ignored
        clear_logs();
        pulse_start();
        push_word(32'd3);
        push_word(32'h1111_2222);
        tx_q.push_back(8'h01);
        send(100);
        pulse_start();
        chk("ign_busy", 32'(busy0), 32'd1);
        tx_q.push_back(8'h02);
        tx_q.push_back(8'h03);
        tx_q.push_back(8'h04);
        push_word(32'h5555_6666);
        send(70);
        repeat (4) @(negedge clk);
        chk("ign_nwrites", 32'(log0_d.size()), 32'd3);
        chk("ign_d1", log0_d[1], 32'h0403_0201);
        chk("ign_a2", log0_a[2], 32'h0000_0008);
        chk("ign_done", 32'(done0), 32'd1);

        // randomized sessions
        for (int s = 0; s < 10; s++) begin
            clear_logs();
            pulse_start();
            if ($urandom_range(4) == 0) begin
                n_rand = 65 + $urandom_range(200);
                exp_writes = 0;
            end else begin
                n_rand = 1 + $urandom_range(7);
                exp_writes = n_rand;
            end
            push_word(32'(n_rand));
            for (int w = 0; w < exp_writes; w++) push_word($urandom);
            send(30 + $urandom_range(70));
            repeat (4) @(negedge clk);
            chk("rand_nwrites", 32'(log0_d.size()), 32'(exp_writes));
            chk("rand_status", 32'({done0, error0}), (exp_writes == 0) ? 32'd1 : 32'd2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
